// File: rtl/tv_pkg.sv
// Shared TV timing package: zone encoding, PAL default timing, NTSC alternates,
// and the half-line limit helper used by the counters and the zone decoder.
package tv_pkg;

  typedef enum logic [1:0] {
    BROAD   = 2'd0,
    EQ_POST = 2'd1,
    ACTIVE  = 2'd2,
    EQ_PRE  = 2'd3
  } zone_e;

  // Plain-vector zone codes for state compares in legacy-style logic
  localparam logic [1:0] Z_BROAD   = BROAD;
  localparam logic [1:0] Z_EQ_POST = EQ_POST;
  localparam logic [1:0] Z_ACTIVE  = ACTIVE;
  localparam logic [1:0] Z_EQ_PRE  = EQ_PRE;

  // PAL timing in 24 MHz-ish clocks
  localparam int PAL_HALFLINE  = 768;
  localparam int PAL_FIELD_HL  = 625;
  localparam int PAL_HSYNC_W   = 114;
  localparam int PAL_NARROW_W  = 56;
  localparam int PAL_BROAD_W   = 655;
  localparam int PAL_BURST_ST  = 138;
  localparam int PAL_BURST_LEN = 75;
  localparam int PAL_BLANK_END = 249;
  localparam int PAL_BLANK_ST  = 1496;

  // NTSC alternates
  localparam int NTSC_HALFLINE = 762;
  localparam int NTSC_FIELD_HL = 525;

  // Last half-line index of a field: interlaced fields carry one extra half-line
  function automatic logic [10:0] hl_limit(input logic il, input int field_hl);
    return il ? 11'(field_hl - 1) : 11'(field_hl - 2);
  endfunction

endpackage

// File: rtl/tv_zone_fsm.sv
// Vertical zone decode: classifies the current half-line into broad pulses,
// post-equalising, active picture or pre-equalising, relative to the field limit.
module tv_zone_fsm
  import tv_pkg::*;
(
  input  logic [10:0] halfline,
  input  logic [10:0] limit,
  output logic [1:0]  zone
);

  // Zone follows the half-line index; the last seven half-lines are pre-equalising
  always_comb begin
    zone = Z_ACTIVE;
    if (halfline < 11'd5)
      zone = Z_BROAD;
    else if (halfline < 11'd10)
      zone = Z_EQ_POST;
    else if (halfline > limit - 11'd7)
      zone = Z_EQ_PRE;
  end

endmodule

// File: rtl/tv_sync_gen.sv
// Composite TV sync generator: pixel/half-line/line counters, vertical zone
// decode and registered sync, blank, burst and strobe outputs.
// Optional feature macro: TV_SYNC_GEN_EXTRESYNC_EN (falling edge of vsync_ext
// forces a field boundary).
module tv_sync_gen
  import tv_pkg::*;
#(
  parameter int HALFLINE  = PAL_HALFLINE,
  parameter int FIELD_HL  = PAL_FIELD_HL,
  parameter int HSYNC_W   = PAL_HSYNC_W,
  parameter int NARROW_W  = PAL_NARROW_W,
  parameter int BROAD_W   = PAL_BROAD_W,
  parameter int BURST_ST  = PAL_BURST_ST,
  parameter int BURST_LEN = PAL_BURST_LEN,
  parameter int BLANK_END = PAL_BLANK_END,
  parameter int BLANK_ST  = PAL_BLANK_ST
)(
  input  logic        clk24,
  input  logic        reset,
  input  logic        ce,
  input  logic        interlace,
  input  logic        fieldalt,
  input  logic        vsync_ext,
  output logic        tv_sync,
  output logic        tv_blank,
  output logic        tv_burst,
  output logic [10:0] halfline,
  output logic [10:0] pixel,
  output logic        field,
  output logic        v_switch,
  output logic        field_start,
  output logic        line_start
);

  localparam logic [10:0] PIX_MAX  = 11'(HALFLINE - 1);
  localparam logic [10:0] LPOS_MAX = 11'(2 * HALFLINE - 1);
  localparam logic [10:0] BROAD_C  = 11'(BROAD_W);
  localparam logic [10:0] NARROW_C = 11'(NARROW_W);
  localparam logic [10:0] HSYNC_C  = 11'(HSYNC_W);
  localparam logic [10:0] BURST_LO = 11'(BURST_ST);
  localparam logic [10:0] BURST_HI = 11'(BURST_ST + BURST_LEN);
  localparam logic [10:0] BEND_C   = 11'(BLANK_END);
  localparam logic [10:0] BST_C    = 11'(BLANK_ST);

  logic [10:0] pix_c, hl_c, lpos_c, lpos_inc, limit;
  logic        field_c, il_q, fs_flag, ext_hit, end_hl, end_field;
  logic [1:0]  zone;
  logic        sync_c, blank_c, burst_c;

  // Field length is fixed by the interlace mode latched at the last boundary
  assign limit     = hl_limit(il_q, FIELD_HL);
  assign end_hl    = (pix_c == PIX_MAX);
  assign end_field = end_hl && (hl_c == limit);
  assign lpos_inc  = (lpos_c == LPOS_MAX) ? 11'd0 : lpos_c + 11'd1;

`ifdef TV_SYNC_GEN_EXTRESYNC_EN
  logic vs_d1, vs_d2, ext_pend;

  // Register vsync_ext and hold a detected falling edge until the next ce
  always_ff @(posedge clk24) begin
    if (reset) begin
      vs_d1    <= 1'b0;
      vs_d2    <= 1'b0;
      ext_pend <= 1'b0;
    end else begin
      vs_d1    <= vsync_ext;
      vs_d2    <= vs_d1;
      ext_pend <= ce ? 1'b0 : ext_hit;
    end
  end

  assign ext_hit = ext_pend | (vs_d2 & ~vs_d1);
`else
  logic unused_vsync;
  assign unused_vsync = vsync_ext;
  assign ext_hit      = 1'b0;
`endif

  tv_zone_fsm u_zone (
    .halfline (hl_c),
    .limit    (limit),
    .zone     (zone)
  );

  // Counter state: pixel within half-line, half-line within field, line position
  always_ff @(posedge clk24) begin
    if (reset) begin
      pix_c   <= 11'd0;
      hl_c    <= 11'd0;
      lpos_c  <= 11'd0;
      field_c <= 1'b0;
      il_q    <= interlace;
      fs_flag <= 1'b0;
    end else if (ce) begin
      if (ext_hit) begin
        pix_c   <= 11'd0;
        hl_c    <= 11'd0;
        lpos_c  <= 11'd0;
        field_c <= ~field_c;
        il_q    <= interlace;
        fs_flag <= 1'b1;
      end else begin
        pix_c   <= end_hl ? 11'd0 : pix_c + 11'd1;
        fs_flag <= end_field;
        if (end_field) begin
          hl_c    <= 11'd0;
          field_c <= ~field_c;
          il_q    <= interlace;
          // Progressive fields realign to a line start; interlaced ones keep phase
          lpos_c  <= interlace ? lpos_inc : 11'd0;
        end else begin
          if (end_hl)
            hl_c <= hl_c + 11'd1;
          lpos_c <= lpos_inc;
        end
      end
    end
  end

  // Sync, blank and burst decode from the current counter state
  always_comb begin
    sync_c = 1'b1;
    case (zone)
      Z_BROAD:            if (pix_c < BROAD_C)   sync_c = 1'b0;
      Z_EQ_POST, Z_EQ_PRE: if (pix_c < NARROW_C) sync_c = 1'b0;
      default:            if (lpos_c < HSYNC_C)  sync_c = 1'b0;
    endcase
    blank_c = (lpos_c < BEND_C) || (lpos_c > BST_C) || (zone != Z_ACTIVE);
    burst_c = (zone == Z_ACTIVE) && (lpos_c > BURST_LO) && (lpos_c < BURST_HI);
  end

  // Output register: one clock behind the counters, frozen while ce is low
  always_ff @(posedge clk24) begin
    if (reset) begin
      tv_sync     <= 1'b1;
      tv_blank    <= 1'b1;
      tv_burst    <= 1'b0;
      halfline    <= 11'd0;
      pixel       <= 11'd0;
      field       <= 1'b0;
      v_switch    <= 1'b0;
      field_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (ce) begin
      tv_sync     <= sync_c;
      tv_blank    <= blank_c;
      tv_burst    <= burst_c;
      halfline    <= hl_c;
      pixel       <= pix_c;
      field       <= field_c;
      v_switch    <= hl_c[1] ^ (fieldalt & field_c);
      field_start <= fs_flag;
      line_start  <= (lpos_c == 11'd0);
    end else begin
      field_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule
